// File: rtl/vsdma_pkg.sv
// Shared definitions for the multi-channel vsdma arbiter: side FSM encoding,
// default widths and the round-robin index helper.
package vsdma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REQ   = 2'd2,
        ST_BUSY  = 2'd3
    } rr_state_e;

    localparam int DEF_CH_NUM      = 4;
    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_DATA_WIDTH  = 256;
    localparam int DEF_SIZE_WIDTH  = 16;
    localparam int DEF_REQ_TIMEOUT = 1024;
    localparam int ID_WIDTH        = 3;

    // (base + step) mod n, used both for the scan order and for ptr advance
    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                     input int unsigned step,
                                                     input int unsigned n);
        int unsigned sum;
        sum = (32'(base) + step) % n;
        return ID_WIDTH'(sum);
    endfunction

endpackage

// File: rtl/vsdma_rr_side.sv
// One arbitration side (write or read): round-robin FSM, request timeout and
// the valid/ready routing between the granted channel and the master port.
module vsdma_rr_side
    import vsdma_pkg::*;
#(
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
    parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]   ch_addr_i,
    input  logic [CH_NUM-1:0]              ch_areq_i,
    input  logic [CH_NUM*SIZE_WIDTH-1:0]   ch_size_i,
    output logic [CH_NUM-1:0]              ch_ack_o,
    output logic [CH_NUM-1:0]              ch_busy_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic                           m_areq_o,
    output logic [SIZE_WIDTH-1:0]          m_size_o,
    input  logic                           m_busy_i,
    input  logic [CH_NUM-1:0]              ch_gather_i,
    output logic                           m_gather_o,
    input  logic                           m_scatter_i,
    output logic [CH_NUM-1:0]              ch_scatter_o,
    output logic [ID_WIDTH-1:0]            grant_id_o,
    output logic                           timeout_err_o
);

    localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);

    rr_state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d, gid_q, gid_d;
    logic [CH_NUM-1:0]       ack_q, ack_d, busy_q, busy_d;
    logic                    areq_q, areq_d, tout_q, tout_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SIZE_WIDTH-1:0]   size_q, size_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    found_s, hit_s, mux_act_s;
    logic [ID_WIDTH-1:0]     pick_s;
    logic [CH_NUM-1:0]       pick_oh_s, sel_oh_s;
    logic [ADDR_WIDTH-1:0]   pick_addr_s;
    logic [SIZE_WIDTH-1:0]   pick_size_s;

    // First requester in round-robin order starting at ptr
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        pick_s  = ptr_q;
        for (int k = 0; k < CH_NUM; k++) begin
            for (int j = 0; j < CH_NUM; j++) begin
                hit_s   = !found_s && ch_areq_i[j] && (rr_index(ptr_q, k, CH_NUM) == ID_WIDTH'(j));
                pick_s  = hit_s ? ID_WIDTH'(j) : pick_s;
                found_s = found_s | hit_s;
            end
        end
    end

    // One-hot decode of candidate/granted channel and candidate addr/size
    always_comb begin
        pick_oh_s   = '0;
        sel_oh_s    = '0;
        pick_addr_s = '0;
        pick_size_s = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            pick_oh_s[j] = (pick_s == ID_WIDTH'(j));
            sel_oh_s[j]  = (gid_q == ID_WIDTH'(j));
            pick_addr_s  = pick_oh_s[j] ? ch_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH] : pick_addr_s;
            pick_size_s  = pick_oh_s[j] ? ch_size_i[j*SIZE_WIDTH +: SIZE_WIDTH] : pick_size_s;
        end
    end

    // Next-state logic; ack/busy/areq are computed one cycle ahead so they leave registers
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = '0;
        busy_d  = busy_q;
        areq_d  = areq_q;
        tout_d  = tout_q;
        addr_d  = addr_q;
        size_d  = size_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s && !m_busy_i) begin
                    state_d = ST_GRANT;
                    gid_d   = pick_s;
                    ack_d   = pick_oh_s;
                    busy_d  = pick_oh_s;
                    addr_d  = pick_addr_s;
                    size_d  = pick_size_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (size_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = '0;
                    ptr_d   = rr_index(gid_q, 1, CH_NUM);
                end else begin
                    state_d = ST_REQ;
                    areq_d  = 1'b1;
                end
            end
            ST_REQ: begin
                if (m_busy_i) begin
                    state_d = ST_BUSY;
                    areq_d  = 1'b0;
                end else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
                    // master never accepted: give the slot up and flag it
                    state_d = ST_IDLE;
                    areq_d  = 1'b0;
                    tout_d  = 1'b1;
                    busy_d  = '0;
                    ptr_d   = rr_index(gid_q, 1, CH_NUM);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (!m_busy_i) begin
                    state_d = ST_IDLE;
                    busy_d  = '0;
                    ptr_d   = rr_index(gid_q, 1, CH_NUM);
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = '0;
                areq_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            busy_q  <= '0;
            areq_q  <= 1'b0;
            tout_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            areq_q  <= areq_d;
            tout_q  <= tout_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mux_act_s     = (state_q == ST_REQ) || (state_q == ST_BUSY);
    assign m_gather_o    = mux_act_s & (|(ch_gather_i & sel_oh_s));
    assign ch_scatter_o  = (mux_act_s & m_scatter_i) ? sel_oh_s : '0;
    assign ch_ack_o      = ack_q;
    assign ch_busy_o     = busy_q;
    assign m_addr_o      = addr_q;
    assign m_areq_o      = areq_q;
    assign m_size_o      = size_q;
    assign grant_id_o    = gid_q;
    assign timeout_err_o = tout_q;

endmodule

// File: rtl/vsdma_mch_arb.sv
// Shares one vsdma master port among CH_NUM user channels, with independent
// round-robin arbitration of the write and read sides.
module vsdma_mch_arb
    import vsdma_pkg::*;
#(
    parameter int CH_NUM      = DEF_CH_NUM,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SIZE_WIDTH  = DEF_SIZE_WIDTH,
    parameter int REQ_TIMEOUT = DEF_REQ_TIMEOUT
) (
    input  logic                         ui_clk,
    input  logic                         ui_rst,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_waddr,
    input  logic [CH_NUM-1:0]            ch_wareq,
    input  logic [CH_NUM*SIZE_WIDTH-1:0] ch_wsize,
    output logic [CH_NUM-1:0]            ch_wack,
    output logic [CH_NUM-1:0]            ch_wbusy,
    input  logic [CH_NUM*DATA_WIDTH-1:0] ch_wdata,
    input  logic [CH_NUM-1:0]            ch_wvalid,
    output logic [CH_NUM-1:0]            ch_wready,
    input  logic [CH_NUM*ADDR_WIDTH-1:0] ch_raddr,
    input  logic [CH_NUM-1:0]            ch_rareq,
    input  logic [CH_NUM*SIZE_WIDTH-1:0] ch_rsize,
    output logic [CH_NUM-1:0]            ch_rack,
    output logic [CH_NUM-1:0]            ch_rbusy,
    output logic [CH_NUM*DATA_WIDTH-1:0] ch_rdata,
    output logic [CH_NUM-1:0]            ch_rvalid,
    input  logic [CH_NUM-1:0]            ch_rready,
    output logic [ADDR_WIDTH-1:0]        vsdma_waddr,
    output logic                         vsdma_wareq,
    output logic [SIZE_WIDTH-1:0]        vsdma_wsize,
    input  logic                         vsdma_wbusy,
    output logic [DATA_WIDTH-1:0]        vsdma_wdata,
    output logic                         vsdma_wvalid,
    input  logic                         vsdma_wready,
    output logic [ADDR_WIDTH-1:0]        vsdma_raddr,
    output logic                         vsdma_rareq,
    output logic [SIZE_WIDTH-1:0]        vsdma_rsize,
    input  logic                         vsdma_rbusy,
    input  logic [DATA_WIDTH-1:0]        vsdma_rdata,
    input  logic                         vsdma_rvalid,
    output logic                         vsdma_rready,
    output logic [2:0]                   wr_grant_id,
    output logic [2:0]                   rd_grant_id,
    output logic [1:0]                   timeout_err
);

    logic wr_tout_s, rd_tout_s;

    vsdma_rr_side #(
        .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH), .REQ_TIMEOUT(REQ_TIMEOUT)
    ) u_wr_side (
        .clk_i(ui_clk), .rst_i(ui_rst),
        .ch_addr_i(ch_waddr), .ch_areq_i(ch_wareq), .ch_size_i(ch_wsize),
        .ch_ack_o(ch_wack), .ch_busy_o(ch_wbusy),
        .m_addr_o(vsdma_waddr), .m_areq_o(vsdma_wareq), .m_size_o(vsdma_wsize),
        .m_busy_i(vsdma_wbusy),
        .ch_gather_i(ch_wvalid), .m_gather_o(vsdma_wvalid),
        .m_scatter_i(vsdma_wready), .ch_scatter_o(ch_wready),
        .grant_id_o(wr_grant_id), .timeout_err_o(wr_tout_s)
    );

    // on the read side valid flows master->channel and ready channel->master
    vsdma_rr_side #(
        .CH_NUM(CH_NUM), .ADDR_WIDTH(ADDR_WIDTH), .SIZE_WIDTH(SIZE_WIDTH), .REQ_TIMEOUT(REQ_TIMEOUT)
    ) u_rd_side (
        .clk_i(ui_clk), .rst_i(ui_rst),
        .ch_addr_i(ch_raddr), .ch_areq_i(ch_rareq), .ch_size_i(ch_rsize),
        .ch_ack_o(ch_rack), .ch_busy_o(ch_rbusy),
        .m_addr_o(vsdma_raddr), .m_areq_o(vsdma_rareq), .m_size_o(vsdma_rsize),
        .m_busy_i(vsdma_rbusy),
        .ch_gather_i(ch_rready), .m_gather_o(vsdma_rready),
        .m_scatter_i(vsdma_rvalid), .ch_scatter_o(ch_rvalid),
        .grant_id_o(rd_grant_id), .timeout_err_o(rd_tout_s)
    );

    // Write data follows the granted channel; qualification is carried by wvalid
    always_comb begin
        vsdma_wdata = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            vsdma_wdata = (wr_grant_id == 3'(j)) ? ch_wdata[j*DATA_WIDTH +: DATA_WIDTH] : vsdma_wdata;
        end
    end

    assign ch_rdata    = {CH_NUM{vsdma_rdata}};
    assign timeout_err = {rd_tout_s, wr_tout_s};

endmodule

// File: tb/tb_vsdma_mch_arb.sv
// Directed bench for vsdma_mch_arb: round-robin order, zero-size grant,
// request timeout, concurrent write/read routing and mid-transfer reset.
module tb_vsdma_mch_arb;

    localparam int CH = 4;
    localparam int AW = 28;
    localparam int DW = 256;
    localparam int SW = 16;
    localparam int TO = 64;

    logic              ui_clk = 1'b0;
    logic              ui_rst;
    logic [CH*AW-1:0]  ch_waddr, ch_raddr;
    logic [CH-1:0]     ch_wareq, ch_rareq, ch_wack, ch_rack, ch_wbusy, ch_rbusy;
    logic [CH*SW-1:0]  ch_wsize, ch_rsize;
    logic [CH*DW-1:0]  ch_wdata, ch_rdata;
    logic [CH-1:0]     ch_wvalid, ch_wready, ch_rvalid, ch_rready;
    logic [AW-1:0]     vsdma_waddr, vsdma_raddr;
    logic              vsdma_wareq, vsdma_rareq, vsdma_wbusy, vsdma_rbusy;
    logic [SW-1:0]     vsdma_wsize, vsdma_rsize;
    logic [DW-1:0]     vsdma_wdata, vsdma_rdata;
    logic              vsdma_wvalid, vsdma_wready, vsdma_rvalid, vsdma_rready;
    logic [2:0]        wr_grant_id, rd_grant_id;
    logic [1:0]        timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_areq;

    vsdma_mch_arb #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .REQ_TIMEOUT(TO)) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .ch_waddr(ch_waddr), .ch_wareq(ch_wareq), .ch_wsize(ch_wsize), .ch_wack(ch_wack),
        .ch_wbusy(ch_wbusy), .ch_wdata(ch_wdata), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .ch_raddr(ch_raddr), .ch_rareq(ch_rareq), .ch_rsize(ch_rsize), .ch_rack(ch_rack),
        .ch_rbusy(ch_rbusy), .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_rready(ch_rready),
        .vsdma_waddr(vsdma_waddr), .vsdma_wareq(vsdma_wareq), .vsdma_wsize(vsdma_wsize),
        .vsdma_wbusy(vsdma_wbusy), .vsdma_wdata(vsdma_wdata), .vsdma_wvalid(vsdma_wvalid),
        .vsdma_wready(vsdma_wready),
        .vsdma_raddr(vsdma_raddr), .vsdma_rareq(vsdma_rareq), .vsdma_rsize(vsdma_rsize),
        .vsdma_rbusy(vsdma_rbusy), .vsdma_rdata(vsdma_rdata), .vsdma_rvalid(vsdma_rvalid),
        .vsdma_rready(vsdma_rready),
        .wr_grant_id(wr_grant_id), .rd_grant_id(rd_grant_id), .timeout_err(timeout_err)
    );

    always #5 ui_clk = ~ui_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] addr_of(input int ch);
        return AW'(28'h0ABC000 + ch * 28'h0001111);
    endfunction

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the grant of channel ch and run one write burst with the master busy for bcyc cycles
    task automatic serve_w(input int ch, input int bcyc);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ch_wack != '0) break;
        end
        check("w_ack", DW'(ch_wack), DW'(4'b0001 << ch));
        check("w_grant_id", DW'(wr_grant_id), DW'(ch));
        check("w_busy_onehot", DW'(ch_wbusy), DW'(4'b0001 << ch));
        ch_wareq[ch] = 1'b0;
        tick();
        check("w_ack_pulse", DW'(ch_wack), DW'(0));
        check("w_areq_high", DW'(vsdma_wareq), DW'(1));
        check("w_addr", DW'(vsdma_waddr), DW'(addr_of(ch)));
        check("w_size", DW'(vsdma_wsize), DW'(ch_wsize[ch*SW +: SW]));
        vsdma_wbusy = 1'b1;
        tick();
        check("w_areq_drop", DW'(vsdma_wareq), DW'(0));
        check("w_busy_hold", DW'(ch_wbusy), DW'(4'b0001 << ch));
        repeat (bcyc - 1) tick();
        vsdma_wbusy = 1'b0;
        tick();
        check("w_busy_release", DW'(ch_wbusy), DW'(0));
        check("w_gid_hold", DW'(wr_grant_id), DW'(ch));
    endtask

    initial begin
        ui_rst = 1'b1;
        ch_wareq = '0; ch_rareq = '0; ch_wvalid = '0; ch_rready = '0;
        ch_wdata = '0; vsdma_wbusy = 1'b0; vsdma_rbusy = 1'b0; vsdma_rdata = '0;
        vsdma_wready = 1'b0; vsdma_rvalid = 1'b0;
        for (int i = 0; i < CH; i++) begin
            ch_waddr[i*AW +: AW] = addr_of(i);
            ch_raddr[i*AW +: AW] = addr_of(i + 8);
            ch_wsize[i*SW +: SW] = 16'd16;
            ch_rsize[i*SW +: SW] = 16'd8;
        end
        tick(); tick();
        check("rst_wack", DW'(ch_wack), DW'(0));
        check("rst_wbusy", DW'(ch_wbusy), DW'(0));
        check("rst_wareq", DW'(vsdma_wareq), DW'(0));
        check("rst_waddr", DW'(vsdma_waddr), DW'(0));
        check("rst_gid", DW'({wr_grant_id, rd_grant_id}), DW'(0));
        check("rst_terr", DW'(timeout_err), DW'(0));
        ui_rst = 1'b0;

        // Outside REQ/BUSY the data-path routing stays closed
        vsdma_wready = 1'b1; vsdma_rvalid = 1'b1; ch_wvalid = 4'hF; ch_rready = 4'hF;
        #1;
        check("idle_wready", DW'(ch_wready), DW'(0));
        check("idle_rvalid", DW'(ch_rvalid), DW'(0));
        check("idle_wvalid", DW'(vsdma_wvalid), DW'(0));
        check("idle_rready", DW'(vsdma_rready), DW'(0));
        vsdma_wready = 1'b0; vsdma_rvalid = 1'b0; ch_wvalid = '0; ch_rready = '0;

        // Master busy already high in IDLE blocks any grant
        vsdma_wbusy = 1'b1;
        ch_wareq = 4'hF;
        repeat (3) tick();
        check("busy_idle_noack", DW'(ch_wack), DW'(0));
        check("busy_idle_nobusy", DW'(ch_wbusy), DW'(0));
        vsdma_wbusy = 1'b0;

        // All four requesting: served 0,1,2,3
        serve_w(0, 20);
        serve_w(1, 20);
        serve_w(2, 20);
        serve_w(3, 20);
        check("rr_all_done", DW'(ch_wack | ch_wbusy), DW'(0));

        // ch2 served, then ch0 and ch3 together: ptr=3 picks ch3 first
        ch_wareq = 4'b0100;
        serve_w(2, 3);
        ch_wareq = 4'b1001;
        serve_w(3, 3);
        serve_w(0, 3);

        // Zero-size request on ch1: ack only, no master request, ptr advances to 2
        ch_wsize[1*SW +: SW] = 16'd0;
        ch_wareq = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ch_wack != '0) break;
        end
        check("z_ack", DW'(ch_wack), DW'(4'b0010));
        ch_wareq = '0;
        tick();
        check("z_no_areq", DW'(vsdma_wareq), DW'(0));
        check("z_busy_clr", DW'(ch_wbusy), DW'(0));
        tick();
        check("z_no_areq2", DW'(vsdma_wareq), DW'(0));
        ch_wsize[1*SW +: SW] = 16'd16;
        ch_wareq = 4'b0101;
        serve_w(2, 2);
        serve_w(0, 2);

        // Timeout: ch1 granted, master never busy; areq lasts exactly TO cycles
        ch_wareq = 4'b0110;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ch_wack != '0) break;
        end
        check("to_ack", DW'(ch_wack), DW'(4'b0010));
        ch_wareq[1] = 1'b0;
        n_areq = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (vsdma_wareq) n_areq++;
            else break;
        end
        check("to_areq_cycles", DW'(n_areq), DW'(TO));
        check("to_err", DW'(timeout_err), DW'(2'b01));
        check("to_busy_clr", DW'(ch_wbusy), DW'(0));
        serve_w(2, 2);
        check("to_err_sticky", DW'(timeout_err), DW'(2'b01));

        // Concurrent write ch0 (ptr=3 -> ch0) and read ch3 (ptr=0 -> ch3)
        ch_wareq = 4'b0001;
        ch_rareq = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ch_wack != '0) break;
        end
        check("c_wack", DW'(ch_wack), DW'(4'b0001));
        check("c_rack", DW'(ch_rack), DW'(4'b1000));
        check("c_rgid", DW'(rd_grant_id), DW'(3));
        ch_wareq = '0; ch_rareq = '0;
        tick();
        check("c_both_areq", DW'({vsdma_wareq, vsdma_rareq}), DW'(2'b11));
        check("c_raddr", DW'(vsdma_raddr), DW'(addr_of(11)));
        check("c_rsize", DW'(vsdma_rsize), DW'(8));
        vsdma_rdata = {8{32'hC0DE_5A5A}};
        vsdma_rvalid = 1'b1;
        ch_rready = 4'b1000;
        ch_wdata[0 +: DW] = {8{32'h1234_ABCD}};
        ch_wdata[DW +: DW] = {8{32'hDEAD_BEEF}};
        ch_wvalid = 4'b0011;
        vsdma_wready = 1'b1;
        #1;
        check("c_rvalid_route", DW'(ch_rvalid), DW'(4'b1000));
        check("c_rready", DW'(vsdma_rready), DW'(1));
        check("c_rdata_bcast", ch_rdata[2*DW +: DW], {8{32'hC0DE_5A5A}});
        check("c_wvalid", DW'(vsdma_wvalid), DW'(1));
        check("c_wdata", vsdma_wdata, {8{32'h1234_ABCD}});
        check("c_wready_route", DW'(ch_wready), DW'(4'b0001));
        ch_rready = 4'b0111;
        #1;
        check("c_rready_other", DW'(vsdma_rready), DW'(0));
        ch_rready = 4'b1000;
        vsdma_wbusy = 1'b1; vsdma_rbusy = 1'b1;
        tick();
        check("c_busy_both", DW'({ch_wbusy, ch_rbusy}), DW'(8'b0001_1000));

        // Reset mid-BUSY: everything drops at once
        #2;
        ui_rst = 1'b1;
        #1;
        check("r_busy", DW'({ch_wbusy, ch_rbusy}), DW'(0));
        check("r_valid_ready", DW'({vsdma_wvalid, vsdma_rready, ch_wready, ch_rvalid}), DW'(0));
        check("r_gid", DW'({wr_grant_id, rd_grant_id}), DW'(0));
        check("r_terr", DW'(timeout_err), DW'(0));
        check("r_areq", DW'({vsdma_wareq, vsdma_rareq}), DW'(0));
        vsdma_wbusy = 1'b0; vsdma_rbusy = 1'b0; vsdma_rvalid = 1'b0; vsdma_wready = 1'b0;
        ch_wvalid = '0; ch_rready = '0;
        tick();
        ui_rst = 1'b0;
        ch_wareq = 4'b1110;
        serve_w(1, 2);
        ch_wareq = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vsdma_mch_arb.md
VSDMA_MCH_ARB -- requirements
Module: vsdma_mch_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of user channels sharing one vsdma port (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 28: vsdma address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 256: vsdma data width.
REQ-004 SHALL have parameter SIZE_WIDTH, default 16: burst-size field width.
REQ-005 SHALL have parameter REQ_TIMEOUT, default 1024: maximum cycles a master request may wait for busy.
REQ-006 SHALL use one clock and an asynchronous, active-high reset: ui_clk  in  1  sole clock; ui_rst  in  1  async active-high reset.
REQ-007 SHALL have these per-channel flattened ports, channel i at slice i: ch_waddr in CH_NUM*ADDR_WIDTH; ch_wareq in CH_NUM; ch_wsize in CH_NUM*SIZE_WIDTH; ch_wack out CH_NUM; ch_wbusy out CH_NUM; ch_wdata in CH_NUM*DATA_WIDTH; ch_wvalid in CH_NUM; ch_wready out CH_NUM.
REQ-008 SHALL have these per-channel read ports, channel i at slice i: ch_raddr in CH_NUM*ADDR_WIDTH; ch_rareq in CH_NUM; ch_rsize in CH_NUM*SIZE_WIDTH; ch_rack out CH_NUM; ch_rbusy out CH_NUM; ch_rdata out CH_NUM*DATA_WIDTH; ch_rvalid out CH_NUM; ch_rready in CH_NUM.
REQ-009 SHALL have these master write ports: vsdma_waddr out ADDR_WIDTH; vsdma_wareq out 1; vsdma_wsize out SIZE_WIDTH; vsdma_wbusy in 1; vsdma_wdata out DATA_WIDTH; vsdma_wvalid out 1; vsdma_wready in 1.
REQ-010 SHALL have these master read ports: vsdma_raddr, vsdma_rareq, vsdma_rsize, vsdma_rbusy in, vsdma_rdata in, vsdma_rvalid in, vsdma_rready out. Widths mirror the write side.
REQ-011 SHALL have status ports: wr_grant_id out 3, rd_grant_id out 3, timeout_err out 2 (bit0 write, bit1 read, sticky).

Function
REQ-012 Write and read sides SHALL be arbitrated independently and concurrently, using identical logic.
REQ-013 Each side SHALL run the FSM IDLE -> GRANT -> REQ -> BUSY -> IDLE.
REQ-014 IDLE: when any ch_*areq is high and master *busy is low, the FSM SHALL select the first requester scanning round-robin from ptr, then go to GRANT.
REQ-015 GRANT, one cycle: the FSM SHALL latch the selected channel's addr/size, pulse ch_*ack[sel] for exactly 1 cycle, and assert ch_*busy[sel]. Latched size==0 SHALL go straight to IDLE with ptr=sel+1 and no master request.
REQ-016 REQ: vsdma_*areq SHALL be held high with the latched addr/size until master *busy is sampled high, then the FSM goes to BUSY. Areq SHALL drop in the same cycle busy is sampled.
REQ-017 BUSY: on master *busy falling, the FSM SHALL deassert ch_*busy[sel], set ptr=sel+1 mod CH_NUM, and go to IDLE. The next grant SHALL occur no earlier than the following cycle.
REQ-018 Write data mux: vsdma_wdata/wvalid SHALL equal the granted channel's values, and vsdma_wready SHALL route only to ch_wready[sel]. The mux SHALL be combinational with zero latency, active in REQ/BUSY only; otherwise wvalid=0 and all ch_wready=0.
REQ-019 Read data: vsdma_rdata SHALL be broadcast to every ch_rdata slice. vsdma_rvalid SHALL route only to ch_rvalid[sel], and vsdma_rready SHALL be ch_rready[sel], in REQ/BUSY only; otherwise rready=0.
REQ-020 Timeout: a REQ state lasting REQ_TIMEOUT cycles SHALL drop areq, set timeout_err bit, release ch_*busy[sel], advance ptr, and return to IDLE.
REQ-021 A channel dropping areq after ack SHALL NOT affect the current transfer. Areq still high after ack SHALL re-request in a later round only.
REQ-022 If master *busy is already high in IDLE, no grant SHALL be issued until it falls.
REQ-023 *_grant_id SHALL show the last granted channel, and SHALL hold its value through IDLE.

Reset
REQ-024 On ui_rst high, asynchronously: FSMs SHALL go to IDLE, ptr=0, grant_id=0, timeout_err=0, and all ack/busy/valid/ready/areq outputs=0. Latched addr/size SHALL be 0.
REQ-025 Reset asserted mid-transfer SHALL abort without completing handshakes. Release SHALL be synchronous to ui_clk.

Structure
REQ-026 A shared package vsdma_pkg SHALL hold the FSM state encoding, the default widths, and a function computing the round-robin next index.
REQ-027 One sub-module, vsdma_rr_side, SHALL implement one side's FSM, pointer, timeout counter and mux. It SHALL be instantiated twice, once for write and once for read.

Verification
REQ-028 CH_NUM=4, all four wareq high, wsize=16 each, master busy 20 cycles per burst -> grant order 0,1,2,3, each ack 1 cycle, ch_wbusy exclusive.
REQ-029 After ch2 served, ch0 and ch3 requesting -> ch3 granted first (ptr=3).
REQ-030 ch1 request with wsize=0 -> ch_wack[1] pulse, vsdma_wareq stays 0, ptr becomes 2.
REQ-031 Master vsdma_wbusy never rises, REQ_TIMEOUT=64 -> areq drops at cycle 64 of REQ, timeout_err[0]=1, next channel served.
REQ-032 Simultaneous write ch0 and read ch3 transfers -> both master ports active concurrently, and ch_rvalid asserts only on bit 3.
REQ-033 ui_rst pulsed mid-BUSY -> all outputs 0 within the same cycle, ptr=0, next grant goes to the lowest requester.
